// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator stage that sits
// downstream of the 4x4 array multiplier.
package product_acc_pkg;

    // Width of the unsigned product coming out of the multiplier.
    localparam int PROD_W_DEF = 8;

    // Width of the out_count field. Frames hold 1..15 products.
    localparam int CNT_W = 4;

    // Default accumulator width.
    localparam int ACC_W_DEF = 12;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage : product_acc_pkg

// File: rtl/product_accumulator_if.sv
// Product-in / frame-sum-out handshake bundle. master = upstream/consumer
// side (testbench or parent), slave = the accumulator itself.
interface product_accumulator_if #(
    parameter int PROD_W = product_acc_pkg::PROD_W_DEF,
    parameter int ACC_W  = product_acc_pkg::ACC_W_DEF
);
    logic                              in_valid;
    logic                              in_ready;
    logic [PROD_W-1:0]                 in_product;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [ACC_W-1:0]                  out_sum;
    logic [product_acc_pkg::CNT_W-1:0] out_count;
    logic                              out_ovf;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface : product_accumulator_if

// File: rtl/acc_add.sv
// Combinational ACC_W + PROD_W adder with carry-out. When ACC_SATURATE_EN is
// defined the sum is clamped to all-ones on carry instead of wrapping.
module acc_add
    import product_acc_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign carry_o  = wide_sum[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, any further non-zero product carries again and re-clamps,
    // so the sum stays pinned at the maximum for the rest of the frame.
    assign sum_o = carry_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    assign sum_o = wide_sum[ACC_W-1:0];
`endif

endmodule : acc_add

// File: rtl/product_accumulator.sv
// Frame accumulator: sums up to COUNT_N products per frame and holds the result
// behind a valid/ready handshake. Optional clamp mode: define ACC_SATURATE_EN.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int COUNT_N = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    product_accumulator_if.slave        bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    acc_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_acc_add (
        .acc_i   (acc_q),
        .prod_i  (bus.in_product),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default before the case, so no
        // path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_carry;
                    if ((cnt_q == LAST_CNT) || bus.in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready depends only on registered state and reset, never on out_ready.
    assign bus.in_ready  = rst_n && (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule : product_accumulator
